// File: rtl/gs_pkg.sv
// Shared types and constants for the Gauss-Seidel issue controller.
package gs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SUB,
    WAIT,
    MUL,
    GAP
  } gs_state_e;

  localparam int N_LANE      = 4;
  localparam int SUB_PER_ROW = 3;
  localparam int WAIT_CYC    = 2;

  // k-th lane of {0..N_LANE-1} with the row's own lane removed
  function automatic logic [1:0] skip_lane(input logic [1:0] row, input logic [1:0] k);
    return (k < row) ? k : k + 2'd1;
  endfunction

endpackage

// File: rtl/gs_operand_sel.sv
// Operand-A select: x register slice, multiply forward (D2 hit) or subtract forward.
module gs_operand_sel
  import gs_pkg::*;
(
  input  logic [32*N_LANE-1:0] x_data,
  input  logic [31:0]          mul_forw,
  input  logic [31:0]          sub_forw,
  input  logic [1:0]           lane,
  input  logic                 use_sub,
  input  logic                 d2_m_en,
  input  logic [1:0]           d2_idx,
  output logic [31:0]          operand_a
);

  always_comb begin
    operand_a = x_data[32*lane +: 32];
    if (use_sub) begin
      operand_a = sub_forw;
    end else if (d2_m_en && (d2_idx == lane)) begin
      operand_a = mul_forw;
    end
  end

endmodule

// File: rtl/gs_issue_ctrl.sv
// Issue stage for the 4-lane Gauss-Seidel core: three subtracts then one multiply per row.
// Optional stall counter output o_stall_cnt when GS_ISSUE_STATS_EN is defined.
module gs_issue_ctrl
  import gs_pkg::*;
#(
  parameter int ITER_W = 6
`ifdef GS_ISSUE_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ITER_W-1:0] i_iter,
  input  logic              i_row_valid,
  output logic              o_row_ready,
  input  logic [47:0]       i_row_coef,
  input  logic [15:0]       i_row_recip,
  input  logic [127:0]      i_x_data,
  input  logic [31:0]       i_mul_forw,
  output logic [31:0]       o_inst_A,
  output logic [15:0]       o_inst_B,
  output logic [1:0]        o_idx,
  output logic              o_m_en,
  output logic              o_s_en,
  output logic              o_s_last,
  output logic              o_zero,
  input  logic [31:0]       i_sub_forw,
  output logic              o_busy,
`ifdef GS_ISSUE_STATS_EN
  output logic [STAT_W-1:0] o_stall_cnt,
`endif
  output logic              o_done
);

  gs_state_e         state_q, state_d;
  logic [1:0]        cnt_q, row_q, k, lane;
  logic [ITER_W-1:0] iter_q, sweep_q;
  logic [ITER_W:0]   sweep_nx;
  logic [47:0]       coef_q;
  logic [15:0]       recip_q;
  logic              sh0_m_en, sh1_m_en;
  logic [1:0]        sh0_idx, sh1_idx;
  logic              start_ok, more_sweeps, last_mul;
  logic [31:0]       opsel_a, a_d;
  logic [15:0]       b_d;
  logic [1:0]        idx_d;
  logic              m_en_d, s_en_d, s_last_d, zero_d, use_sub, busy_d;

  assign start_ok    = i_start && (state_q == IDLE) && !o_busy;
  assign sweep_nx    = {1'b0, sweep_q} + (ITER_W+1)'(1);
  assign more_sweeps = sweep_nx < {1'b0, iter_q};
  assign last_mul    = (state_q == MUL) && (row_q == 2'd3) && !more_sweeps;
  assign k           = 2'd2 - cnt_q;
  assign lane        = skip_lane(row_q, k);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD;
      LOAD:    if (i_row_valid) state_d = SUB;
      SUB:     if (cnt_q == 2'd0) state_d = WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = MUL;
      MUL:     state_d = last_mul ? IDLE : GAP;
      GAP:     state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    b_d      = '0;
    idx_d    = '0;
    m_en_d   = 1'b0;
    s_en_d   = 1'b0;
    s_last_d = 1'b0;
    zero_d   = 1'b1;
    use_sub  = 1'b0;
    case (state_q)
      SUB: begin
        s_en_d   = 1'b1;
        zero_d   = 1'b0;
        idx_d    = row_q;
        s_last_d = (cnt_q == 2'd0);
        case (k)
          2'd0:    b_d = coef_q[15:0];
          2'd1:    b_d = coef_q[31:16];
          default: b_d = coef_q[47:32];
        endcase
      end
      MUL: begin
        m_en_d  = 1'b1;
        zero_d  = 1'b0;
        idx_d   = row_q;
        b_d     = recip_q;
        use_sub = 1'b1;
      end
      default: ;
    endcase
    a_d    = (s_en_d || m_en_d) ? opsel_a : 32'd0;
    busy_d = (state_d != IDLE) || last_mul;
  end

  gs_operand_sel u_opsel (
    .x_data    (i_x_data),
    .mul_forw  (i_mul_forw),
    .sub_forw  (i_sub_forw),
    .lane      (lane),
    .use_sub   (use_sub),
    .d2_m_en   (sh1_m_en),
    .d2_idx    (sh1_idx),
    .operand_a (opsel_a)
  );

  // cnt_q: remaining SUB issues, then remaining WAIT bubbles (down-counter)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iter_q  <= '0;
      sweep_q <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      coef_q  <= '0;
      recip_q <= '0;
    end else begin
      if (start_ok) begin
        iter_q  <= (i_iter == '0) ? ITER_W'(1) : i_iter;
        sweep_q <= '0;
        row_q   <= '0;
      end
      case (state_q)
        LOAD: if (i_row_valid) begin
          coef_q  <= i_row_coef;
          recip_q <= i_row_recip;
          cnt_q   <= 2'(SUB_PER_ROW - 1);
        end
        SUB:  cnt_q <= (cnt_q == 2'd0) ? 2'(WAIT_CYC - 1) : cnt_q - 2'd1;
        WAIT: cnt_q <= cnt_q - 2'd1;
        MUL: begin
          row_q <= row_q + 2'd1;
          if (row_q == 2'd3) sweep_q <= sweep_q + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inst_A    <= '0;
      o_inst_B    <= '0;
      o_idx       <= '0;
      o_m_en      <= 1'b0;
      o_s_en      <= 1'b0;
      o_s_last    <= 1'b0;
      o_zero      <= 1'b1;
      o_row_ready <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      sh0_m_en    <= 1'b0;
      sh1_m_en    <= 1'b0;
      sh0_idx     <= '0;
      sh1_idx     <= '0;
    end else begin
      o_inst_A    <= a_d;
      o_inst_B    <= b_d;
      o_idx       <= idx_d;
      o_m_en      <= m_en_d;
      o_s_en      <= s_en_d;
      o_s_last    <= s_last_d;
      o_zero      <= zero_d;
      o_row_ready <= (state_d == LOAD);
      o_busy      <= busy_d;
      o_done      <= last_mul;
      sh0_m_en    <= o_m_en;
      sh0_idx     <= o_idx;
      sh1_m_en    <= sh0_m_en;
      sh1_idx     <= sh0_idx;
    end
  end

`ifdef GS_ISSUE_STATS_EN
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == LOAD) && !i_row_valid && (stall_q != '1)) begin
      stall_q <= stall_q + STAT_W'(1);
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_gs_issue_ctrl.sv
// Randomized bench for gs_issue_ctrl against a row-timeline reference model.
module tb_gs_issue_ctrl;

  localparam int ITER_W = 6;
  localparam int MAXC   = 1024;
  localparam int ASZ    = MAXC + 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [ITER_W-1:0] i_iter = '0;
  logic              i_row_valid = 1'b0;
  logic              o_row_ready;
  logic [47:0]       i_row_coef = '0;
  logic [15:0]       i_row_recip = '0;
  logic [127:0]      i_x_data = '0;
  logic [31:0]       i_mul_forw = '0;
  logic [31:0]       o_inst_A;
  logic [15:0]       o_inst_B;
  logic [1:0]        o_idx;
  logic              o_m_en, o_s_en, o_s_last, o_zero;
  logic [31:0]       i_sub_forw = '0;
  logic              o_busy, o_done;
`ifdef GS_ISSUE_STATS_EN
  logic [15:0]       o_stall_cnt;
`endif

  gs_issue_ctrl #(.ITER_W(ITER_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_iter(i_iter),
    .i_row_valid(i_row_valid), .o_row_ready(o_row_ready), .i_row_coef(i_row_coef),
    .i_row_recip(i_row_recip), .i_x_data(i_x_data), .i_mul_forw(i_mul_forw),
    .o_inst_A(o_inst_A), .o_inst_B(o_inst_B), .o_idx(o_idx), .o_m_en(o_m_en),
    .o_s_en(o_s_en), .o_s_last(o_s_last), .o_zero(o_zero), .i_sub_forw(i_sub_forw),
    .o_busy(o_busy),
`ifdef GS_ISSUE_STATS_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // observed trace (cycle c = sampled 1 time unit after posedge c)
  logic        obs_m [ASZ], obs_s [ASZ], obs_last [ASZ], obs_zero [ASZ];
  logic        obs_ready [ASZ], obs_busy [ASZ], obs_done [ASZ];
  logic [1:0]  obs_idx [ASZ];
  logic [15:0] obs_b [ASZ];
  logic [31:0] obs_a [ASZ];
  logic [127:0] drv_x [ASZ];
  logic [31:0] drv_mf [ASZ], drv_sf [ASZ];
  // model expectations: kind 0 bubble, 1 subtract, 2 multiply
  int          exp_kind [ASZ];
  logic [1:0]  exp_idx [ASZ], exp_j [ASZ];
  logic [15:0] exp_b [ASZ];
  logic        exp_last [ASZ], exp_ready [ASZ];
  int          ncyc, exp_done, obs_done_cyc, done_pulses, stall_exp;
  logic [47:0] tok_coef [16];
  logic [15:0] tok_recip [16];

  task automatic rand_tokens();
    for (int t = 0; t < 16; t++) begin
      tok_coef[t]  = {16'($urandom), 16'($urandom), 16'($urandom)};
      tok_recip[t] = 16'($urandom);
    end
  endtask

  // Drives one job, records DUT outputs and builds the expected timeline.
  // A row token is accepted on the first valid cycle at or after its load window opens;
  // its subtracts show up 2..4 cycles later, its multiply 7 cycles later, next window at +8.
  task automatic run_op(input int iter, input int valid_pct, input int restart_at,
                        input int stall_first, input int fwd_cyc);
    int eff, total, n, win, kk;
    bit waiting, v;
    logic [1:0] row;
    logic [127:0] x;
    logic [31:0] mf;
    eff = (iter == 0) ? 1 : iter;
    total = 4 * eff;
    n = 0; win = 1; waiting = 1'b1;
    exp_done = -1; obs_done_cyc = -1; done_pulses = 0; stall_exp = 0; ncyc = 0;
    for (int c = 0; c < ASZ; c++) begin
      exp_kind[c] = 0; exp_idx[c] = 0; exp_j[c] = 0; exp_b[c] = 0;
      exp_last[c] = 0; exp_ready[c] = 0;
    end
    for (int c = 0; c < MAXC; c++) begin
      obs_m[c] = o_m_en; obs_s[c] = o_s_en; obs_last[c] = o_s_last; obs_zero[c] = o_zero;
      obs_ready[c] = o_row_ready; obs_busy[c] = o_busy; obs_done[c] = o_done;
      obs_idx[c] = o_idx; obs_b[c] = o_inst_B; obs_a[c] = o_inst_A;
      if (o_done) begin
        done_pulses++;
        if (obs_done_cyc < 0) obs_done_cyc = c;
      end
      ncyc = c + 1;
      if (exp_done >= 0 && c >= exp_done + 3) break;
      v = (c >= 1 + stall_first) && (($urandom % 100) < valid_pct);
      exp_ready[c] = waiting && (c >= win);
      i_row_valid = v;
      i_row_coef  = (n < total) ? tok_coef[n] : {16'($urandom), 32'($urandom)};
      i_row_recip = (n < total) ? tok_recip[n] : 16'($urandom);
      if (exp_ready[c]) begin
        if (!v) begin
          stall_exp++;
        end else begin
          row = 2'(n % 4);
          kk = 0;
          for (int l = 0; l < 4; l++) begin
            if (l != int'(row)) begin
              exp_kind[c+2+kk] = 1;
              exp_idx[c+2+kk]  = row;
              exp_j[c+2+kk]    = 2'(l);
              exp_b[c+2+kk]    = tok_coef[n][16*kk +: 16];
              exp_last[c+2+kk] = (kk == 2);
              kk++;
            end
          end
          exp_kind[c+7] = 2;
          exp_idx[c+7]  = row;
          exp_b[c+7]    = tok_recip[n];
          n++;
          if (n == total) begin
            waiting = 1'b0;
            exp_done = c + 7;
          end else begin
            win = c + 8;
          end
        end
      end
      x  = {$urandom, $urandom, $urandom, $urandom};
      mf = $urandom;
      if (c == fwd_cyc) begin
        mf = 32'h0001_2345;
        x[31:0] = 32'hDEAD_0000;
      end
      drv_x[c] = x; drv_mf[c] = mf; drv_sf[c] = $urandom;
      i_x_data = x; i_mul_forw = mf; i_sub_forw = drv_sf[c];
      i_start = (c == 0) || (c == restart_at);
      i_iter  = (c == 0) ? ITER_W'(iter) : ITER_W'($urandom);
      @(posedge i_clk); #1;
    end
    i_start = 1'b0;
    i_row_valid = 1'b0;
  endtask

  task automatic test_reset();
    int ops;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", o_zero); end
    checks++; if ({o_m_en, o_s_en, o_s_last} !== 3'b000) begin errors++; $display("FAIL reset_en got %b exp 000", {o_m_en, o_s_en, o_s_last}); end
    checks++; if ({o_row_ready, o_busy, o_done} !== 3'b000) begin errors++; $display("FAIL reset_hs got %b exp 000", {o_row_ready, o_busy, o_done}); end
    checks++; if ({o_inst_A, o_inst_B, o_idx} !== 50'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {o_inst_A, o_inst_B, o_idx}); end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    i_row_valid = 1'b1; i_iter = ITER_W'(1); i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    checks++; if (o_s_en !== 1'b1) begin errors++; $display("FAIL reset_pre_sub got %b exp 1", o_s_en); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if ({o_zero, o_s_en, o_busy} !== 3'b100) begin errors++; $display("FAIL reset_mid_sub got %b exp 100", {o_zero, o_s_en, o_busy}); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    ops = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clk); #1;
      if (!o_zero || o_busy || o_m_en || o_s_en) ops++;
    end
    checks++; if (ops !== 0) begin errors++; $display("FAIL reset_no_ops got %0d active cycles exp 0", ops); end
    i_row_valid = 1'b0;
  endtask

  task automatic test_single_sweep();
    rand_tokens();
    tok_coef[0]  = 48'h0003_0002_0001;
    tok_recip[0] = 16'h4000;
    run_op(1, 100, -1, 0, -1);
    for (int c = 3; c <= 5; c++) begin
      checks++;
      if ({obs_s[c], obs_m[c], obs_zero[c], obs_idx[c], obs_b[c], obs_last[c]} !==
          {1'b1, 1'b0, 1'b0, 2'd0, 16'(c - 2), c == 5}) begin
        errors++;
        $display("FAIL single_sub cyc %0d got s%b m%b z%b idx%0d B%h last%b", c, obs_s[c],
                 obs_m[c], obs_zero[c], obs_idx[c], obs_b[c], obs_last[c]);
      end
      checks++;
      if (obs_a[c] !== drv_x[c-1][32*(c-2) +: 32]) begin
        errors++; $display("FAIL single_subA cyc %0d got %h exp %h", c, obs_a[c], drv_x[c-1][32*(c-2) +: 32]);
      end
    end
    checks++;
    if ({obs_m[8], obs_s[8], obs_idx[8], obs_b[8], obs_a[8]} !== {1'b1, 1'b0, 2'd0, 16'h4000, drv_sf[7]}) begin
      errors++; $display("FAIL single_mul got m%b B%h A%h exp B4000 A%h", obs_m[8], obs_b[8], obs_a[8], drv_sf[7]);
    end
    checks++; if (obs_done_cyc !== 32) begin errors++; $display("FAIL single_done got cyc %0d exp 32", obs_done_cyc); end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", done_pulses); end
  endtask

  task automatic test_mul_forwarding();
    rand_tokens();
    run_op(1, 100, -1, 0, 10);
    checks++;
    if ({obs_m[8], obs_idx[8]} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL fwd_prev_mul got m%b idx%0d exp m1 idx0", obs_m[8], obs_idx[8]);
    end
    checks++;
    if ({obs_s[11], obs_idx[11], obs_a[11]} !== {1'b1, 2'd1, 32'h0001_2345}) begin
      errors++; $display("FAIL fwd_hit got s%b idx%0d A%h exp s1 idx1 A00012345", obs_s[11], obs_idx[11], obs_a[11]);
    end
    checks++;
    if (obs_a[19] !== drv_x[18][31:0]) begin
      errors++; $display("FAIL fwd_miss got A%h exp %h", obs_a[19], drv_x[18][31:0]);
    end
  endtask

  task automatic test_stall();
    int bad;
    rand_tokens();
    run_op(1, 100, -1, 5, -1);
    bad = 0;
    for (int c = 1; c <= 6; c++) if (obs_ready[c] !== 1'b1 || obs_zero[c] !== 1'b1 || obs_s[c] || obs_m[c]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad); end
    checks++; if ({obs_s[7], obs_s[8]} !== 2'b01) begin errors++; $display("FAIL stall_first_sub got %b exp 01", {obs_s[7], obs_s[8]}); end
    checks++; if (obs_done_cyc !== 37) begin errors++; $display("FAIL stall_done got cyc %0d exp 37", obs_done_cyc); end
`ifdef GS_ISSUE_STATS_EN
    checks++; if (o_stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt got %0d exp 5", o_stall_cnt); end
`endif
  endtask

  task automatic test_multi_sweep();
    int muls, bad;
    rand_tokens();
    run_op(3, 100, -1, 0, -1);
    muls = 0; bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (obs_m[c]) begin
        if (obs_idx[c] !== 2'(muls % 4)) bad++;
        muls++;
      end
    end
    checks++; if (muls !== 12) begin errors++; $display("FAIL multi_muls got %0d exp 12", muls); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL multi_row_wrap got %0d bad idx exp 0", bad); end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL multi_pulses got %0d exp 1", done_pulses); end
    checks++; if (obs_done_cyc !== 96) begin errors++; $display("FAIL multi_done got cyc %0d exp 96", obs_done_cyc); end
  endtask

  task automatic test_start_while_busy();
    int rs;
    for (int r = 0; r < 2; r++) begin
      rs = (r == 0) ? 10 : 32;
      rand_tokens();
      run_op(1, 100, rs, 0, -1);
      checks++; if (obs_done_cyc !== 32) begin errors++; $display("FAIL busy_start_done rs %0d got cyc %0d exp 32", rs, obs_done_cyc); end
      checks++; if (done_pulses !== 1) begin errors++; $display("FAIL busy_start_pulses rs %0d got %0d exp 1", rs, done_pulses); end
      checks++;
      if ({obs_busy[33], obs_zero[33], obs_zero[34], obs_ready[34]} !== 4'b0110) begin
        errors++; $display("FAIL busy_start_after rs %0d got %b exp 0110", rs,
                           {obs_busy[33], obs_zero[33], obs_zero[34], obs_ready[34]});
      end
    end
  endtask

  task automatic test_random();
    int it, pct, rs;
    logic eb;
    logic [3:0] ec;
    logic [31:0] ea;
    for (int r = 0; r < 12; r++) begin
      it  = $urandom % 4;
      pct = 40 + $urandom % 61;
      rs  = ($urandom % 2 == 1) ? 1 + $urandom % 30 : -1;
      rand_tokens();
      run_op(it, pct, rs, 0, -1);
      checks++; if (obs_done_cyc !== exp_done) begin errors++; $display("FAIL rand_done run %0d got cyc %0d exp %0d", r, obs_done_cyc, exp_done); end
      for (int c = 1; c < ncyc; c++) begin
        case (exp_kind[c])
          1:       ec = {1'b0, 1'b1, 1'b0, exp_last[c]};
          2:       ec = 4'b1000;
          default: ec = 4'b0010;
        endcase
        eb = (exp_done < 0) || (c <= exp_done);
        checks++;
        if ({obs_m[c], obs_s[c], obs_zero[c], obs_last[c]} !== ec) begin
          errors++; $display("FAIL rand_ctrl run %0d cyc %0d got %b exp %b", r, c,
                             {obs_m[c], obs_s[c], obs_zero[c], obs_last[c]}, ec);
        end
        checks++;
        if ({obs_ready[c], obs_busy[c], obs_done[c]} !== {exp_ready[c], eb, c == exp_done}) begin
          errors++; $display("FAIL rand_hs run %0d cyc %0d got %b exp %b", r, c,
                             {obs_ready[c], obs_busy[c], obs_done[c]}, {exp_ready[c], eb, c == exp_done});
        end
        if (exp_kind[c] != 0) begin
          if (exp_kind[c] == 2) ea = drv_sf[c-1];
          else if (exp_kind[c-3] == 2 && exp_idx[c-3] == exp_j[c]) ea = drv_mf[c-1];
          else ea = drv_x[c-1][32*exp_j[c] +: 32];
          checks++;
          if ({obs_idx[c], obs_b[c], obs_a[c]} !== {exp_idx[c], exp_b[c], ea}) begin
            errors++; $display("FAIL rand_op run %0d cyc %0d got idx%0d B%h A%h exp idx%0d B%h A%h", r, c,
                               obs_idx[c], obs_b[c], obs_a[c], exp_idx[c], exp_b[c], ea);
          end
        end
      end
`ifdef GS_ISSUE_STATS_EN
      checks++; if (o_stall_cnt !== 16'(stall_exp)) begin errors++; $display("FAIL rand_stall_cnt run %0d got %0d exp %0d", r, o_stall_cnt, stall_exp); end
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    @(posedge i_clk); #1;
    test_single_sweep();
    test_mul_forwarding();
    test_stall();
    test_multi_sweep();
    test_start_while_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
